// File: rtl/instr_fifo_pkg.sv
// Shared width/depth defaults for the decode-to-dispatch instruction queue.
// The macros are guarded so a front-end define.vh can override them.
`ifndef DECODE_INFO_DW
`define DECODE_INFO_DW 32
`endif
`ifndef INSTR_FIFO_AW
`define INSTR_FIFO_AW 4
`endif
`ifndef INSTR_FIFO_AF_SLACK
`define INSTR_FIFO_AF_SLACK 2
`endif

package instr_fifo_pkg;

  localparam int unsigned IF_DW       = `DECODE_INFO_DW;
  localparam int unsigned IF_AW       = `INSTR_FIFO_AW;
  localparam int unsigned IF_AF_SLACK = `INSTR_FIFO_AF_SLACK;

  // Bit positions inside the sticky error vector.
  localparam int unsigned ERR_OVF_BIT = 0;
  localparam int unsigned ERR_UDF_BIT = 1;

endpackage

// File: rtl/instr_fifo_ram.sv
// DP x DW register array: one synchronous write port, one asynchronous read port.
module instr_fifo_ram
  import instr_fifo_pkg::*;
#(
  parameter int unsigned DW = IF_DW,
  parameter int unsigned AW = IF_AW
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DP = 1 << AW;

  logic [DW-1:0] mem_q [DP];

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fifo.sv
// First-word-fall-through instruction queue between decode and dispatch,
// with flush, full/almost-full back-pressure and sticky overflow/underflow flags.
module instr_fifo
  import instr_fifo_pkg::*;
#(
  parameter int unsigned DW       = IF_DW,
  parameter int unsigned AW       = IF_AW,
  parameter int unsigned AF_SLACK = IF_AF_SLACK
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [DW-1:0] decode_microInstr_push,
  input  logic          instrFifo_push,
  output logic          instrFifo_full,
  output logic          instrFifo_almostFull,
  output logic [DW-1:0] decode_microInstr_pop,
  input  logic          instrFifo_pop,
  output logic          instrFifo_empty,
  output logic [AW:0]   instrFifo_count,
  input  logic          flush,
  output logic [1:0]    fifo_err_qout
);

  localparam int unsigned DP     = 1 << AW;
  localparam logic [AW:0] DP_CNT = (AW+1)'(DP);
  localparam logic [AW:0] AF_CNT = (AW+1)'(DP - AF_SLACK);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic [1:0]  err_q, err_d;
  logic        full, empty, push_ok, pop_ok;

  // Status comes from registered state only, so stalls never see a comb path from push/pop.
  assign full    = (count_q == DP_CNT);
  assign empty   = (wptr_q == rptr_q);
  assign push_ok = instrFifo_push & ~full;
  assign pop_ok  = instrFifo_pop & ~empty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    err_d   = err_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      if (instrFifo_push && full)  err_d[ERR_OVF_BIT] = 1'b1;
      if (instrFifo_pop  && empty) err_d[ERR_UDF_BIT] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  instr_fifo_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .CLK   (CLK),
    .we    (push_ok & ~flush),
    .waddr (wptr_q[AW-1:0]),
    .wdata (decode_microInstr_push),
    .raddr (rptr_q[AW-1:0]),
    .rdata (decode_microInstr_pop)
  );

  assign instrFifo_full       = full;
  assign instrFifo_almostFull = (count_q >= AF_CNT);
  assign instrFifo_empty      = empty;
  assign instrFifo_count      = count_q;
  assign fifo_err_qout        = err_q;

endmodule

// File: tb/tb_instr_fifo.sv
// Self-checking bench for instr_fifo against a queue-based reference model.
module tb_instr_fifo;
  import instr_fifo_pkg::*;

  localparam int unsigned DW = IF_DW;
  localparam int unsigned AW = IF_AW;
  localparam int unsigned DP = 16;
  localparam int unsigned AF_LEVEL = 14;

  logic          CLK;
  logic          RSTn;
  logic [DW-1:0] decode_microInstr_push;
  logic          instrFifo_push;
  logic          instrFifo_full;
  logic          instrFifo_almostFull;
  logic [DW-1:0] decode_microInstr_pop;
  logic          instrFifo_pop;
  logic          instrFifo_empty;
  logic [AW:0]   instrFifo_count;
  logic          flush;
  logic [1:0]    fifo_err_qout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] model_q [$];
  logic [1:0]    model_err;

  instr_fifo dut (
    .CLK                    (CLK),
    .RSTn                   (RSTn),
    .decode_microInstr_push (decode_microInstr_push),
    .instrFifo_push         (instrFifo_push),
    .instrFifo_full         (instrFifo_full),
    .instrFifo_almostFull   (instrFifo_almostFull),
    .decode_microInstr_pop  (decode_microInstr_pop),
    .instrFifo_pop          (instrFifo_pop),
    .instrFifo_empty        (instrFifo_empty),
    .instrFifo_count        (instrFifo_count),
    .flush                  (flush),
    .fifo_err_qout          (fifo_err_qout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One clock: drive inputs, advance the model on the edge, settle 1 time unit after it.
  task automatic step(input logic psh, input logic [DW-1:0] d, input logic pp,
                      input logic fl, input logic rst_n);
    bit m_full, m_empty;
    RSTn = rst_n;
    instrFifo_push = psh;
    decode_microInstr_push = d;
    instrFifo_pop = pp;
    flush = fl;
    m_full  = (model_q.size() == DP);
    m_empty = (model_q.size() == 0);
    @(posedge CLK);
    if (!rst_n) begin
      model_q.delete();
      model_err = 2'b00;
    end else if (fl) begin
      model_q.delete();
    end else begin
      if (pp) begin
        if (m_empty) model_err[1] = 1'b1;
        else void'(model_q.pop_front());
      end
      if (psh) begin
        if (m_full) model_err[0] = 1'b1;
        else model_q.push_back(d);
      end
    end
    #1;
    instrFifo_push = 1'b0;
    instrFifo_pop = 1'b0;
    flush = 1'b0;
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (instrFifo_empty !== 1'b1 || instrFifo_full !== 1'b0 || instrFifo_almostFull !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got empty=%b full=%b af=%b, want 1 0 0",
               instrFifo_empty, instrFifo_full, instrFifo_almostFull);
    end
    n_cmp++;
    if (instrFifo_count !== '0 || fifo_err_qout !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_count_err: got count=%0d err=%b, want 0 00", instrFifo_count, fifo_err_qout);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] want [3];
    want[0] = DW'(32'h11); want[1] = DW'(32'h22); want[2] = DW'(32'h33);
    for (int i = 0; i < 3; i++) step(1'b1, want[i], 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (instrFifo_count !== 5'd3 || instrFifo_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_fill: got count=%0d empty=%b, want 3 0", instrFifo_count, instrFifo_empty);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (decode_microInstr_pop !== want[i]) begin
        n_bad++;
        $display("FAIL basic_head%0d: got %h, want %h", i, decode_microInstr_pop, want[i]);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    end
    n_cmp++;
    if (instrFifo_empty !== 1'b1 || instrFifo_count !== '0) begin
      n_bad++;
      $display("FAIL basic_drain: got empty=%b count=%0d, want 1 0", instrFifo_empty, instrFifo_count);
    end
  endtask

  task automatic test_full();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DP; i++) begin
      step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (instrFifo_almostFull !== (model_q.size() >= AF_LEVEL) ||
          instrFifo_full !== (model_q.size() == DP) ||
          int'(instrFifo_count) != model_q.size()) begin
        n_bad++;
        $display("FAIL fill_%0d: got count=%0d af=%b full=%b, want count=%0d af=%b full=%b",
                 i, instrFifo_count, instrFifo_almostFull, instrFifo_full, model_q.size(),
                 model_q.size() >= AF_LEVEL, model_q.size() == DP);
      end
    end
    step(1'b1, DW'(32'hDEAD), 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (fifo_err_qout !== 2'b01 || instrFifo_count !== 5'd16 || instrFifo_full !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow: got err=%b count=%0d full=%b, want 01 16 1",
               fifo_err_qout, instrFifo_count, instrFifo_full);
    end
  endtask

  // Push while full is refused even with a concurrent pop (full is registered state).
  task automatic test_full_push_pop();
    step(1'b1, DW'(32'hAA), 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (instrFifo_count !== 5'd15 || instrFifo_full !== 1'b0 || fifo_err_qout !== 2'b01) begin
      n_bad++;
      $display("FAIL full_push_pop: got count=%0d full=%b err=%b, want 15 0 01",
               instrFifo_count, instrFifo_full, fifo_err_qout);
    end
    step(1'b1, DW'(32'hAA), 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (instrFifo_count !== 5'd16 || instrFifo_full !== 1'b1) begin
      n_bad++;
      $display("FAIL refill: got count=%0d full=%b, want 16 1", instrFifo_count, instrFifo_full);
    end
    for (int i = 0; i < DP; i++) begin
      n_cmp++;
      if (decode_microInstr_pop !== model_q[0]) begin
        n_bad++;
        $display("FAIL drain_%0d: got %h, want %h", i, decode_microInstr_pop, model_q[0]);
      end
      if (i == DP - 1) begin
        n_cmp++;
        if (decode_microInstr_pop !== DW'(32'hAA)) begin
          n_bad++;
          $display("FAIL drain_last: got %h, want 000000aa", decode_microInstr_pop);
        end
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    end
  endtask

  task automatic test_stream();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      n_cmp++;
      if (decode_microInstr_pop !== model_q[0]) begin
        n_bad++;
        $display("FAIL stream_head%0d: got %h, want %h", i, decode_microInstr_pop, model_q[0]);
      end
      step(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (instrFifo_count !== 5'd5) begin
        n_bad++;
        $display("FAIL stream_count%0d: got %0d, want 5", i, instrFifo_count);
      end
    end
    n_cmp++;
    if (fifo_err_qout !== 2'b00) begin
      n_bad++;
      $display("FAIL stream_err: got %b, want 00", fifo_err_qout);
    end
  endtask

  task automatic test_underflow_and_reset();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (fifo_err_qout !== 2'b10 || instrFifo_count !== '0 || instrFifo_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL underflow: got err=%b count=%0d empty=%b, want 10 0 1",
               fifo_err_qout, instrFifo_count, instrFifo_empty);
    end
    for (int i = 0; i < 9; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (decode_microInstr_pop !== model_q[0] || instrFifo_count !== 5'd9) begin
      n_bad++;
      $display("FAIL after_underflow: got head=%h count=%0d, want %h 9",
               decode_microInstr_pop, instrFifo_count, model_q[0]);
    end
    step(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (instrFifo_count !== '0 || instrFifo_empty !== 1'b1 || fifo_err_qout !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_reset: got count=%0d empty=%b err=%b, want 0 1 00",
               instrFifo_count, instrFifo_empty, fifo_err_qout);
    end
  endtask

  task automatic test_flush();
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b1);
    step(1'b1, DW'($urandom), 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (instrFifo_empty !== 1'b1 || instrFifo_count !== '0 || fifo_err_qout !== 2'b10) begin
      n_bad++;
      $display("FAIL flush: got empty=%b count=%0d err=%b, want 1 0 10",
               instrFifo_empty, instrFifo_count, fifo_err_qout);
    end
    step(1'b1, DW'(32'h55), 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (decode_microInstr_pop !== DW'(32'h55) || instrFifo_count !== 5'd1) begin
      n_bad++;
      $display("FAIL post_flush: got head=%h count=%0d, want 00000055 1",
               decode_microInstr_pop, instrFifo_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 3, !($urandom_range(0, 199) == 0));
      n_cmp++;
      if (int'(instrFifo_count) != model_q.size() ||
          instrFifo_empty !== (model_q.size() == 0) ||
          instrFifo_full !== (model_q.size() == DP) ||
          instrFifo_almostFull !== (model_q.size() >= AF_LEVEL) ||
          fifo_err_qout !== model_err ||
          (model_q.size() != 0 && decode_microInstr_pop !== model_q[0])) begin
        n_bad++;
        $display("FAIL random_%0d: got count=%0d empty=%b full=%b af=%b err=%b head=%h, want count=%0d err=%b head=%h",
                 i, instrFifo_count, instrFifo_empty, instrFifo_full, instrFifo_almostFull,
                 fifo_err_qout, decode_microInstr_pop, model_q.size(), model_err,
                 (model_q.size() != 0) ? model_q[0] : '0);
      end
    end
  endtask

  initial begin
    RSTn = 1'b0;
    instrFifo_push = 1'b0;
    instrFifo_pop = 1'b0;
    flush = 1'b0;
    decode_microInstr_push = '0;
    model_err = 2'b00;
    #2;
    test_reset();
    test_basic();
    test_full();
    test_full_push_pop();
    test_stream();
    test_underflow_and_reset();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
